// File: rtl/rs_age_issue_if.sv
// rs_age_issue_if: dispatch, wakeup, branch/store resolve and issue bundle for rs_age_issue
interface rs_age_issue_if #(
  parameter int DISP_W    = 3,
  parameter int ISSUE_W   = 2,
  parameter int CDB_W     = 3,
  parameter int PREG_BITS = 6,
  parameter int BMASK_W   = 4,
  parameter int SQMASK_W  = 8,
  parameter int PAYLOAD_W = 64
);
  localparam int CW = $clog2(DISP_W + 1);
  logic [CW-1:0]                  disp_count;
  logic [DISP_W*PREG_BITS-1:0]    disp_src1, disp_src2;
  logic [DISP_W-1:0]              disp_src1_rdy, disp_src2_rdy;
  logic [DISP_W*BMASK_W-1:0]      disp_bmask;
  logic [DISP_W*SQMASK_W-1:0]     disp_sqmask;
  logic [DISP_W*PAYLOAD_W-1:0]    disp_payload;
  logic [CW-1:0]                  free_spots;
  logic [CDB_W-1:0]               cdb_valid;
  logic [CDB_W*PREG_BITS-1:0]     cdb_tag;
  logic [SQMASK_W-1:0]            sq_clear;
  logic [ISSUE_W-1:0]             issue_fu_ready, issue_valid;
  logic [ISSUE_W*PAYLOAD_W-1:0]   issue_payload;
  logic [ISSUE_W*BMASK_W-1:0]     issue_bmask;
  logic [BMASK_W-1:0]             br_resolve;
  logic                           br_mispred;
  modport master (
    output disp_count, disp_src1, disp_src2, disp_src1_rdy, disp_src2_rdy, disp_bmask,
           disp_sqmask, disp_payload, cdb_valid, cdb_tag, sq_clear, issue_fu_ready,
           br_resolve, br_mispred,
    input  free_spots, issue_valid, issue_payload, issue_bmask
  );
  modport slave (
    input  disp_count, disp_src1, disp_src2, disp_src1_rdy, disp_src2_rdy, disp_bmask,
           disp_sqmask, disp_payload, cdb_valid, cdb_tag, sq_clear, issue_fu_ready,
           br_resolve, br_mispred,
    output free_spots, issue_valid, issue_payload, issue_bmask
  );
endinterface

// File: rtl/rs_age_issue.sv
// rs_age_issue: age-matrix reservation station with CDB wakeup, branch squash and oldest-first issue.
// Define RS_CDB_BYPASS_EN to let a same-cycle CDB match make a stored entry issuable (0-cycle wakeup).
module rs_age_issue #(
  parameter int DEPTH     = 16,
  parameter int DISP_W    = 3,
  parameter int ISSUE_W   = 2,
  parameter int CDB_W     = 3,
  parameter int PREG_BITS = 6,
  parameter int BMASK_W   = 4,
  parameter int SQMASK_W  = 8,
  parameter int PAYLOAD_W = 64
) (
  input logic           clock,
  input logic           reset,
  rs_age_issue_if.slave rs_io
);
  localparam int CW = $clog2(DISP_W + 1);
  localparam int NW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     valid_q, valid_d, r1_q, r1_d, r2_q, r2_d;
  logic [PREG_BITS-1:0] s1_q [DEPTH], s1_d [DEPTH], s2_q [DEPTH], s2_d [DEPTH];
  logic [BMASK_W-1:0]   bm_q [DEPTH], bm_d [DEPTH];
  logic [SQMASK_W-1:0]  sq_q [DEPTH], sq_d [DEPTH];
  logic [PAYLOAD_W-1:0] pl_q [DEPTH], pl_d [DEPTH];
  logic [DEPTH-1:0]     age_q [DEPTH], age_d [DEPTH], older [DEPTH];

  logic [DEPTH-1:0]     w1, w2, sqsh, r1_now, r2_now, rdy, taken, busy, dsel, found_m;
  logic [DEPTH-1:0]     cand [ISSUE_W], gsel [ISSUE_W], dcol [DEPTH];
  logic [CW-1:0]        dslot [DEPTH];
  logic                 found;
  logic [PREG_BITS-1:0] in_s1 [DEPTH], in_s2 [DEPTH];
  logic [BMASK_W-1:0]   in_bm [DEPTH];
  logic [SQMASK_W-1:0]  in_sq [DEPTH];
  logic [ISSUE_W-1:0]   iv;
  logic [ISSUE_W*PAYLOAD_W-1:0] ip;
  logic [ISSUE_W*BMASK_W-1:0]   ib;
  logic [NW-1:0]        nfree;

  function automatic logic woken(input logic [PREG_BITS-1:0] tag, input logic [CDB_W-1:0] v,
                                 input logic [CDB_W*PREG_BITS-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < CDB_W; j++) hit |= v[j] && t[j*PREG_BITS +: PREG_BITS] == tag;
    return hit;
  endfunction

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w1[e] = woken(s1_q[e], rs_io.cdb_valid, rs_io.cdb_tag);
      w2[e] = woken(s2_q[e], rs_io.cdb_valid, rs_io.cdb_tag);
      sqsh[e] = rs_io.br_mispred & |(bm_q[e] & rs_io.br_resolve);
      for (int c = 0; c < DEPTH; c++) older[e][c] = age_q[c][e];
    end
  end

`ifdef RS_CDB_BYPASS_EN
  assign r1_now = r1_q | w1;
  assign r2_now = r2_q | w2;
`else
  assign r1_now = r1_q;
  assign r2_now = r2_q;
`endif

  always_comb begin
    for (int e = 0; e < DEPTH; e++)
      rdy[e] = valid_q[e] & r1_now[e] & r2_now[e] & ~|sq_q[e] & ~sqsh[e];
  end

  // Each lane picks the entry in its candidate set with no older candidate; a stalled lane leaves it for the next.
  always_comb begin
    taken = '0;
    iv = '0;
    ip = '0;
    ib = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      cand[k] = rdy & ~taken;
      for (int e = 0; e < DEPTH; e++)
        gsel[k][e] = rs_io.issue_fu_ready[k] & ~reset & cand[k][e] & ~|(cand[k] & older[e]);
      taken |= gsel[k];
      iv[k] = |gsel[k];
      for (int e = 0; e < DEPTH; e++)
        if (gsel[k][e]) begin
          ip[k*PAYLOAD_W +: PAYLOAD_W] = pl_q[e];
          ib[k*BMASK_W +: BMASK_W] = bm_q[e] & ~rs_io.br_resolve;
        end
    end
  end

  assign rs_io.issue_valid   = iv;
  assign rs_io.issue_payload = ip;
  assign rs_io.issue_bmask   = ib;

  always_comb begin
    nfree = '0;
    for (int e = 0; e < DEPTH; e++) nfree += NW'(!valid_q[e]);
  end

  assign rs_io.free_spots = (nfree > NW'(DISP_W)) ? CW'(DISP_W) : CW'(nfree);

  // dcol captures everything older than the new entry: prior valid entries plus lower slots this cycle.
  always_comb begin
    busy = valid_q;
    dsel = '0;
    found = 1'b0;
    found_m = '0;
    for (int e = 0; e < DEPTH; e++) begin
      dslot[e] = '0;
      dcol[e] = '0;
    end
    for (int i = 0; i < DISP_W; i++) begin
      found = 1'b0;
      if (i < int'(rs_io.disp_count))
        for (int e = 0; e < DEPTH; e++)
          if (!found && !busy[e]) begin
            found = 1'b1;
            dsel[e] = 1'b1;
            dslot[e] = CW'(i);
            dcol[e] = busy;
            busy[e] = 1'b1;
          end
      found_m = busy;
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      in_s1[e] = rs_io.disp_src1[dslot[e]*PREG_BITS +: PREG_BITS];
      in_s2[e] = rs_io.disp_src2[dslot[e]*PREG_BITS +: PREG_BITS];
      in_bm[e] = rs_io.disp_bmask[dslot[e]*BMASK_W +: BMASK_W];
      in_sq[e] = rs_io.disp_sqmask[dslot[e]*SQMASK_W +: SQMASK_W];
      valid_d[e] = dsel[e] ? ~(rs_io.br_mispred & |(in_bm[e] & rs_io.br_resolve))
                           : valid_q[e] & ~taken[e] & ~sqsh[e];
      s1_d[e] = dsel[e] ? in_s1[e] : s1_q[e];
      s2_d[e] = dsel[e] ? in_s2[e] : s2_q[e];
      r1_d[e] = dsel[e] ? rs_io.disp_src1_rdy[dslot[e]] | woken(in_s1[e], rs_io.cdb_valid, rs_io.cdb_tag)
                        : r1_q[e] | w1[e];
      r2_d[e] = dsel[e] ? rs_io.disp_src2_rdy[dslot[e]] | woken(in_s2[e], rs_io.cdb_valid, rs_io.cdb_tag)
                        : r2_q[e] | w2[e];
      bm_d[e] = (dsel[e] ? in_bm[e] : bm_q[e]) & ~rs_io.br_resolve;
      sq_d[e] = (dsel[e] ? in_sq[e] : sq_q[e]) & ~rs_io.sq_clear;
      pl_d[e] = dsel[e] ? rs_io.disp_payload[dslot[e]*PAYLOAD_W +: PAYLOAD_W] : pl_q[e];
      for (int c = 0; c < DEPTH; c++)
        age_d[e][c] = dsel[c] ? dcol[c][e] : (dsel[e] ? 1'b0 : age_q[e][c]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int e = 0; e < DEPTH; e++) age_q[e] <= '0;
    end else begin
      valid_q <= valid_d;
      age_q <= age_d;
    end
    r1_q <= r1_d;
    r2_q <= r2_d;
    s1_q <= s1_d;
    s2_q <= s2_d;
    bm_q <= bm_d;
    sq_q <= sq_d;
    pl_q <= pl_d;
  end
endmodule
